// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 calculator keypad scanner.
//   state_e    : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   KEY_*      : key codes for the non-digit keys
//   encode_key : (row, col) -> 4-bit key code for the keypad layout
//                  row 0: 1 2 3 A
//                  row 1: 4 5 6 B
//                  row 2: 7 8 9 C
//                  row 3: * 0 # D
//   low_index  : {valid, index} of the single low bit of a 4-bit vector
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_ADD  = 4'hB;
  localparam logic [3:0] KEY_SUB  = 4'hC;
  localparam logic [3:0] KEY_EQ   = 4'hD;
  localparam logic [3:0] KEY_GETM = 4'hE;
  localparam logic [3:0] KEY_SETM = 4'hF;

  function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_ADD;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_SUB;
      4'b11_00: code = KEY_SETM;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_GETM;
      default:  code = KEY_EQ;
    endcase
    return code;
  endfunction

  // Bit 2 flags "exactly one bit low"; bits 1:0 give its position.
  function automatic logic [2:0] low_index(input logic [3:0] v);
    logic [2:0] r;
    case (v)
      4'b1110: r = 3'b1_00;
      4'b1101: r = 3'b1_01;
      4'b1011: r = 3'b1_10;
      4'b0111: r = 3'b1_11;
      default: r = 3'b0_00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// ---------------------------------------------------------------------------
// keypad_if
// Key-code interface between the keypad scanner (master) and the calculator
// control-word decoder (slave).
//   key       : last accepted key code, stable between key_valid strobes
//   key_valid : one-cycle strobe per accepted press (or auto-repeat)
//   key_held  : high while the accepted key remains pressed
// ---------------------------------------------------------------------------
interface keypad_if;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (output key, key_valid, key_held);
  modport slave  (input  key, key_valid, key_held);
endinterface

// File: rtl/keypad_sync.sv
// ---------------------------------------------------------------------------
// keypad_sync
// 4-bit two-flop synchronizer for the asynchronous keypad column lines.
// Resets to all-high (the idle level of the pulled-up columns).
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   async_i : raw column lines
//   sync_o  : synchronized column lines (2 cycles latency)
// ---------------------------------------------------------------------------
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] async_i,
  output logic [3:0] sync_o
);
  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one row per tick (SCAN_DIV cycles),
// debounces press and release over DEBOUNCE_CNT tick samples and presents
// the encoded key on the key-code interface.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   col_in  : keypad columns, active-low, asynchronous
//   row_out : row drive, one-hot-low
//   kp      : keypad_if master (key, key_valid, key_held)
// Optional feature macro: KEYPAD_REPEAT_EN -- while a key is held, re-pulse
// key_valid every REPEAT_TICKS ticks.
// ---------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  keypad_if.master   kp
);
  localparam int unsigned TW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("keypad_scanner: SCAN_DIV >= 4, DEBOUNCE_CNT >= 1, REPEAT_TICKS >= 1 required");
  end

  logic [3:0] col_s;

  keypad_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(col_in),
    .sync_o (col_s)
  );

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    row_q, row_d;         // one-hot-low row drive
  logic [1:0]    row_idx_q, row_idx_d; // index of the driven row
  logic [1:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;         // matching press samples
  logic [CW-1:0] rel_q, rel_d;         // consecutive all-high samples
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  logic       sample;
  logic [2:0] col_dec;
  logic       accept;
  logic       rotate;

  assign sample  = (tick_q == TW'(SCAN_DIV - 1));
  assign col_dec = low_index(col_s);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    row_idx_d = row_idx_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    accept    = 1'b0;
    rotate    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
`endif
    tick_d    = sample ? '0 : tick_q + 1'b1;

    case (state_q)
      SCAN: begin
        if (sample) begin
          if (col_dec[2]) begin
            col_d = col_dec[1:0];
            if (DEBOUNCE_CNT == 1) begin
              accept = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end else begin
            rotate = 1'b1;
          end
        end
      end

      DEBOUNCE: begin
        if (sample) begin
          if (col_dec[2] && (col_dec[1:0] == col_q)) begin
            if (cnt_q == CW'(DEBOUNCE_CNT - 1)) accept = 1'b1;
            else                                cnt_d  = cnt_q + 1'b1;
          end else begin
            // Bounce or a different key: abandon and keep scanning.
            state_d = SCAN;
            cnt_d   = '0;
            rotate  = 1'b1;
          end
        end
      end

      HELD: begin
        if (sample) begin
          if (col_s == 4'b1111) begin
            if (rel_q == CW'(DEBOUNCE_CNT - 1)) begin
              state_d = SCAN;
              held_d  = 1'b0;
              rel_d   = '0;
              rotate  = 1'b1;
            end else begin
              rel_d = rel_q + 1'b1;
            end
          end else begin
            // Still pressed, or a second key: neither counts as release.
            rel_d = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (state_d == HELD) begin
            if (rep_q == RW'(REPEAT_TICKS - 1)) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
`endif
        end
      end

      default: state_d = SCAN;
    endcase

    if (accept) begin
      key_d   = encode_key(row_idx_q, col_d);
      valid_d = 1'b1;
      held_d  = 1'b1;
      state_d = HELD;
      cnt_d   = '0;
      rel_d   = '0;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = '0;
`endif
    end

    if (rotate) begin
      row_d     = {row_q[2:0], row_q[3]};
      row_idx_d = row_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      tick_q    <= '0;
      row_q     <= 4'b1110;
      row_idx_q <= 2'd0;
      col_q     <= 2'd0;
      cnt_q     <= '0;
      rel_q     <= '0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      row_q     <= row_d;
      row_idx_q <= row_idx_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign row_out      = row_q;
  assign kp.key       = key_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Scoreboard bench for keypad_scanner (SCAN_DIV = 4, DEBOUNCE_CNT = 3).
// A behavioural keypad matrix turns the set of pressed keys plus row_out into
// col_in. Stimulus pushes the expected key code of every key_valid strobe
// into a queue; a monitor pops and compares on each strobe.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] pressed = '0;  // bit r*4+c = key at row r, column c is down
  int          tb_cyc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  // Hand-written layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  logic [3:0] code_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hF, 4'h0, 4'hE, 4'hD};

  keypad_if kif ();

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEB),
    .REPEAT_TICKS(REP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .col_in (col_in),
    .row_out(row_out),
    .kp     (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low when its row is driven.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  // Cycle count since reset release; sample edges are every SCAN_DIV cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", nm, act, $time);
    end
  endtask

  // Monitor / scoreboard.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (kif.key_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got key_valid with key %0h, expected none (t=%0t)",
                   kif.key, $time);
        end else begin
          chk("pulse_key", kif.key, exp_q.pop_front());
        end
        chk("pulse_held", kif.key_held, 1);
        if (prev_v) chk("valid_single_cycle", 1, 0);
      end
      prev_v = kif.key_valid;
    end
  end

  // Returns on the falling edge right after a DUT sample edge; inputs changed
  // here are seen by the next sample.
  task automatic next_sample();
    do @(negedge clk); while (tb_cyc % SCAN_DIV != 0);
  endtask

  task automatic wait_held(input logic val, input string nm);
    int i = 0;
    while (kif.key_held !== val && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk(nm, kif.key_held, val);
  endtask

  task automatic align_row(input logic [3:0] rowv);
    int g = 0;
    next_sample();
    while (row_out !== rowv && g < 8) begin
      next_sample();
      g++;
    end
    chk("align_row", row_out, rowv);
  endtask

  logic [3:0] r0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_row_out", row_out, 4'b1110);
    chk("rst_key", kif.key, 0);
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_held", kif.key_held, 0);
    rst = 1'b0;

    // Press 5 for 40 ticks, then release.
    next_sample();
    pressed[5] = 1'b1;
    exp_q.push_back(4'h5);
    repeat (40) next_sample();
    chk("k5_held", kif.key_held, 1);
    chk("k5_key", kif.key, 4'h5);
    pressed = '0;
    next_sample();
    next_sample();
    chk("k5_held_after_2_rel", kif.key_held, 1);
    next_sample();
    chk("k5_held_after_3_rel", kif.key_held, 0);
    chk("k5_row_resume", row_out, 4'b1011);

    // Sweep all 16 keys.
    for (int k = 0; k < 16; k++) begin
      next_sample();
      pressed[k] = 1'b1;
      exp_q.push_back(code_tbl[k]);
      wait_held(1'b1, "sweep_held");
      chk("sweep_key", kif.key, code_tbl[k]);
      next_sample();
      pressed[k] = 1'b0;
      wait_held(1'b0, "sweep_release");
      repeat (2) next_sample();
    end

    // Bounce on 7: 2 samples low, 1 high, 2 low, release.
    align_row(4'b1011);
    pressed[8] = 1'b1;
    next_sample();
    next_sample();
    pressed[8] = 1'b0;
    next_sample();
    align_row(4'b1011);
    pressed[8] = 1'b1;
    next_sample();
    next_sample();
    pressed[8] = 1'b0;
    repeat (8) next_sample();
    chk("bounce_held", kif.key_held, 0);
    r0 = row_out;
    next_sample();
    chk("bounce_rotates", row_out, {r0[2:0], r0[3]});

    // Keys 1 and 2 together, then release 2.
    next_sample();
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    repeat (20) next_sample();
    r0 = row_out;
    next_sample();
    chk("two_keys_rotates", row_out, {r0[2:0], r0[3]});
    chk("two_keys_held", kif.key_held, 0);
    repeat (20) next_sample();
    pressed[1] = 1'b0;
    exp_q.push_back(4'h1);
    wait_held(1'b1, "two_keys_rel2_held");
    chk("two_keys_rel2_key", kif.key, 4'h1);
    next_sample();
    pressed[0] = 1'b0;
    wait_held(1'b0, "two_keys_release");

    // Reset while B is held; B still down afterwards is a new press.
    next_sample();
    pressed[7] = 1'b1;
    exp_q.push_back(4'hB);
    wait_held(1'b1, "rstB_held");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstB_row_out", row_out, 4'b1110);
    chk("rstB_key", kif.key, 0);
    chk("rstB_held", kif.key_held, 0);
    @(negedge clk);
    chk("rstB_valid_next", kif.key_valid, 0);
    chk("rstB_held_next", kif.key_held, 0);
    rst = 1'b0;
    exp_q.push_back(4'hB);
    wait_held(1'b1, "rstB_repress_held");
    chk("rstB_repress_key", kif.key, 4'hB);
    next_sample();
    pressed[7] = 1'b0;
    wait_held(1'b0, "rstB_release");

    // Hold C for well past 2 x REPEAT_TICKS but under 3 x.
    next_sample();
    pressed[11] = 1'b1;
    exp_q.push_back(4'hC);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(4'hC);
    exp_q.push_back(4'hC);
`endif
    wait_held(1'b1, "repC_held");
    repeat (REP * 2 + REP * 3 / 4) next_sample();
    pressed[11] = 1'b0;
    wait_held(1'b0, "repC_release");
    repeat (4) next_sample();

    chk("pulses_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
